pipelined_mac_multiplier: RTL and testbench
===========================================

Name: pipelined_mac_multiplier

Overview:
- Parametrised, pipelined successor to the two-pair muxed multiplier used by the colour-space-conversion and IDCT datapaths.
- Selects one of CHANNELS operand pairs per cycle and multiplies them at full 2*WIDTH precision with fixed latency.
- Optional output mode: round, shift by FRAC_BITS and saturate to WIDTH.
- Optional saturating accumulator for multiply-accumulate (MAC) sequences such as IDCT dot products.
- Back-to-back issue every cycle, no backpressure; the tag travels with each operation.

Parameters:
- WIDTH, 32, operand and result width in bits
- CHANNELS, 4, number of selectable operand pairs (>=2)
- STAGES, 2, latency in cycles from in_valid to out_valid (>=1)
- FRAC_BITS, 16, right-shift applied in rounded mode (0..WIDTH)
- ACC_WIDTH, 64, accumulator width (>=2*WIDTH)
- SIGNED, 1, 1 = two's-complement operands/results, 0 = unsigned

Ports:
- Clock  in  1  system clock, rising edge
- Resetn  in  1  asynchronous, active-low reset
- in_valid  in  1  issue an operation this cycle
- in_sel  in  $clog2(CHANNELS)  operand pair index
- in_a  in  CHANNELS*WIDTH  flattened operand A; channel k = bits [k*WIDTH +: WIDTH]
- in_b  in  CHANNELS*WIDTH  flattened operand B, same packing
- in_mode  in  1  0 = truncate to low WIDTH bits, 1 = round/shift/saturate
- in_acc  in  1  add this product into the accumulator
- in_clr  in  1  with in_acc, accumulator loads the product instead of summing
- out_valid  out  1  result fields valid
- out_sel  out  $clog2(CHANNELS)  in_sel of the emerging operation
- out_product  out  2*WIDTH  full-precision product
- out_result  out  WIDTH  product after the in_mode transform
- out_acc  out  ACC_WIDTH  accumulator value, updated in the out_valid cycle

Behaviour:
- Reset: Resetn low asynchronously clears every pipeline valid bit, every data register and the accumulator. All outputs read 0 while Resetn is low and until the first retired operation.
- Issue: on a rising edge with in_valid=1, the selected pair, in_sel, in_mode, in_acc and in_clr are captured. The captured control bits travel in lockstep with the data.
- in_sel >= CHANNELS: both operands are forced to 0. The operation still retires with out_valid and out_sel = in_sel.
- Latency: exactly STAGES rising edges from issue to out_valid=1. Throughput is 1 operation per cycle. Pipeline bubbles propagate as out_valid=0.
- out_valid=0 cycles: out_product, out_result and out_sel hold their last retired values. out_acc holds its value.
- Product: SIGNED=1 gives a signed WIDTH x WIDTH -> 2*WIDTH multiply; SIGNED=0 gives an unsigned one. The product never overflows.
- in_mode=0: out_result = out_product[WIDTH-1:0]. This is the legacy truncating behaviour.
- in_mode=1, rounding: compute t = (product + 2^(FRAC_BITS-1)) >>> FRAC_BITS. The shift is arithmetic when SIGNED=1. Ties round half-up toward +inf. With FRAC_BITS=0 there is no rounding term.
- in_mode=1, saturation: clamp t to the WIDTH range and drive it on out_result. SIGNED=1 range is [-2^(WIDTH-1), 2^(WIDTH-1)-1]; SIGNED=0 range is [0, 2^WIDTH-1].
- Accumulator, retiring op with in_acc=1: acc <= in_clr ? sext(product) : sat(acc + sext(product)). sat clamps to the ACC_WIDTH range and never wraps.
- Accumulator, in_acc=0: acc is unchanged and in_clr is ignored.
- Consecutive accumulating operations need no gaps. Each op sees the acc value left by the preceding retired op.
- Reset asserted mid-stream discards all in-flight operations. After Resetn rises, no out_valid appears until a new issue plus STAGES cycles.
- Combinational path: none from inputs to outputs. All outputs are registered.

Test Plan:
- Reset: hold Resetn=0 for 3 cycles while toggling inputs -> every output reads 0; after release with in_valid=0, out_valid stays 0.
- Legacy truncate: in_sel=2, a2=3, b2=0xFFFFFFFB (-5), in_mode=0 -> 2 cycles later out_valid=1, out_sel=2, out_product=0xFFFFFFFFFFFFFFF1, out_result=0xFFFFFFF1.
- Rounded mode: in_sel=1, a1=76284, b1=256, in_mode=1 -> out_product=19528704, out_result=298.
- Saturation, positive: a=b=0x7FFFFFFF, in_mode=1 -> out_result=0x7FFFFFFF.
- Saturation, negative: a=0x80000000, b=0x7FFFFFFF, in_mode=1 -> out_result=0x80000000.
- Back-to-back MAC: 8 consecutive issues on channel 0 with a=1..8, b=2, in_acc=1, in_clr=1 on the first only -> out_valid high 8 consecutive cycles, final out_acc=72; then one issue with in_clr=1, a=5, b=5 -> out_acc=25.
- Reset mid-stream: issue 2 ops, drop Resetn one cycle later, release -> no out_valid ever appears for those ops and out_acc=0; a fresh issue retires correctly after 2 cycles.

Source files
------------

// File: rtl/pipelined_mac_multiplier.sv
// Channel-muxed WIDTH x WIDTH multiplier with fixed STAGES latency, an optional
// round/shift/saturate result path and a saturating multiply-accumulate register.
module pipelined_mac_multiplier #(
    parameter int WIDTH     = 32,
    parameter int CHANNELS  = 4,
    parameter int STAGES    = 2,
    parameter int FRAC_BITS = 16,
    parameter int ACC_WIDTH = 64,
    parameter bit SIGNED    = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    input  logic [$clog2(CHANNELS)-1:0]   in_sel_i,
    input  logic [CHANNELS*WIDTH-1:0]     in_a_i,
    input  logic [CHANNELS*WIDTH-1:0]     in_b_i,
    input  logic                          in_mode_i,
    input  logic                          in_acc_i,
    input  logic                          in_clr_i,
    output logic                          out_valid_o,
    output logic [$clog2(CHANNELS)-1:0]   out_sel_o,
    output logic [2*WIDTH-1:0]            out_product_o,
    output logic [WIDTH-1:0]              out_result_o,
    output logic [ACC_WIDTH-1:0]          out_acc_o
);
    localparam int SW = $clog2(CHANNELS);
    localparam int PW = 2 * WIDTH;

    localparam logic [PW:0] RND = ((PW+1)'(1) << FRAC_BITS) >> 1;
    localparam logic signed [PW:0] SMAX = {{(WIDTH+2){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW:0] SMIN = {{(WIDTH+2){1'b1}}, {(WIDTH-1){1'b0}}};
    localparam logic signed [PW:0] UMAX = {{(WIDTH+1){1'b0}}, {WIDTH{1'b1}}};
    localparam logic signed [PW:0] SAT_MAX = SIGNED ? SMAX : UMAX;
    localparam logic signed [PW:0] SAT_MIN = SIGNED ? SMIN : '0;

    typedef struct packed {
        logic          vld;
        logic [SW-1:0] sel;
        logic          mode;
        logic          acc;
        logic          clr;
        logic [PW-1:0] prod;
    } stage_t;

    logic [WIDTH-1:0] op_a, op_b;
    logic [PW-1:0]    ext_a, ext_b;
    stage_t           s0, last;

    // Out-of-range selects leave both operands at zero.
    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (in_sel_i == SW'(k)) begin
                op_a = in_a_i[k*WIDTH +: WIDTH];
                op_b = in_b_i[k*WIDTH +: WIDTH];
            end
        end
        ext_a   = SIGNED ? {{WIDTH{op_a[WIDTH-1]}}, op_a} : {{WIDTH{1'b0}}, op_a};
        ext_b   = SIGNED ? {{WIDTH{op_b[WIDTH-1]}}, op_b} : {{WIDTH{1'b0}}, op_b};
        s0.vld  = in_valid_i;
        s0.sel  = in_sel_i;
        s0.mode = in_mode_i;
        s0.acc  = in_acc_i;
        s0.clr  = in_clr_i;
        s0.prod = ext_a * ext_b;
    end

    // The output register is the final stage, so STAGES-1 intermediate registers.
    if (STAGES == 1) begin : g_direct
        assign last = s0;
    end else begin : g_pipe
        stage_t pipe_q [STAGES-1];
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                for (int i = 0; i < STAGES-1; i++) pipe_q[i] <= '0;
            end else begin
                pipe_q[0] <= s0;
                for (int i = 1; i < STAGES-1; i++) pipe_q[i] <= pipe_q[i-1];
            end
        end
        assign last = pipe_q[STAGES-2];
    end

    logic [PW:0]          prod_x, rx;
    logic signed [PW:0]   t;
    logic [WIDTH-1:0]     result_d;
    logic [ACC_WIDTH-1:0] pe, acc_sat, acc_d, acc_q;
    logic [ACC_WIDTH:0]   sum;
    logic                 ovf;

    always_comb begin
        prod_x = SIGNED ? {last.prod[PW-1], last.prod} : {1'b0, last.prod};
        rx     = prod_x + RND;
        t      = $signed(rx) >>> FRAC_BITS;
        if (!last.mode)       result_d = last.prod[WIDTH-1:0];
        else if (t > SAT_MAX) result_d = SAT_MAX[WIDTH-1:0];
        else if (t < SAT_MIN) result_d = SAT_MIN[WIDTH-1:0];
        else                  result_d = t[WIDTH-1:0];
    end

    // One extra sum bit exposes overflow; saturate instead of wrapping.
    always_comb begin
        if (SIGNED) begin
            pe      = ACC_WIDTH'($signed(last.prod));
            sum     = {acc_q[ACC_WIDTH-1], acc_q} + {pe[ACC_WIDTH-1], pe};
            ovf     = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
            acc_sat = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end else begin
            pe      = ACC_WIDTH'(last.prod);
            sum     = {1'b0, acc_q} + {1'b0, pe};
            ovf     = sum[ACC_WIDTH];
            acc_sat = '1;
        end
        acc_d = last.clr ? pe : (ovf ? acc_sat : sum[ACC_WIDTH-1:0]);
    end

    logic                 valid_q;
    logic [SW-1:0]        sel_q;
    logic [PW-1:0]        product_q;
    logic [WIDTH-1:0]     result_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            sel_q     <= '0;
            product_q <= '0;
            result_q  <= '0;
            acc_q     <= '0;
        end else begin
            valid_q <= last.vld;
            if (last.vld) begin
                sel_q     <= last.sel;
                product_q <= last.prod;
                result_q  <= result_d;
                if (last.acc) acc_q <= acc_d;
            end
        end
    end

    assign out_valid_o   = valid_q;
    assign out_sel_o     = sel_q;
    assign out_product_o = product_q;
    assign out_result_o  = result_q;
    assign out_acc_o     = acc_q;
endmodule

// File: tb/tb_pipelined_mac_multiplier.sv
// Directed vector bench for pipelined_mac_multiplier at default parameters.
module tb_pipelined_mac_multiplier;
    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_mode, in_acc, in_clr;
    logic [1:0]   in_sel;
    logic [127:0] in_a, in_b;
    logic         out_valid;
    logic [1:0]   out_sel;
    logic [63:0]  out_product;
    logic [31:0]  out_result;
    logic [63:0]  out_acc;

    int checks = 0;
    int errors = 0;

    pipelined_mac_multiplier dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_i(in_valid), .in_sel_i(in_sel), .in_a_i(in_a), .in_b_i(in_b),
        .in_mode_i(in_mode), .in_acc_i(in_acc), .in_clr_i(in_clr),
        .out_valid_o(out_valid), .out_sel_o(out_sel), .out_product_o(out_product),
        .out_result_o(out_result), .out_acc_o(out_acc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] a, b;
        logic        mode, acc, clr;
        logic [63:0] p;
        logic [31:0] r;
        logic [63:0] ac;
    } vec_t;

    localparam int N = 11;
    vec_t tv [N];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Unselected channels carry junk so the mux is exercised.
    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] a,
                         input logic [31:0] b, input logic m, input logic ac, input logic cl);
        for (int k = 0; k < 4; k++) begin
            in_a[k*32 +: 32] = $urandom;
            in_b[k*32 +: 32] = $urandom;
        end
        in_a[s*32 +: 32] = a;
        in_b[s*32 +: 32] = b;
        in_valid = v; in_sel = s; in_mode = m; in_acc = ac; in_clr = cl;
    endtask

    task automatic chk_all(input string nm, input logic v, input logic [1:0] s,
                           input logic [63:0] p, input logic [31:0] r, input logic [63:0] ac);
        chk({nm, " valid"},   64'(out_valid), 64'(v));
        chk({nm, " sel"},     64'(out_sel), 64'(s));
        chk({nm, " product"}, out_product, p);
        chk({nm, " result"},  64'(out_result), 64'(r));
        chk({nm, " acc"},     out_acc, ac);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv[0]  = '{2'd2, 32'd3,          32'hFFFFFFFB, 1'b0, 1'b0, 1'b0, 64'hFFFFFFFFFFFFFFF1, 32'hFFFFFFF1, 64'd0};
        tv[1]  = '{2'd1, 32'd76284,      32'd256,      1'b1, 1'b0, 1'b0, 64'd19528704,         32'd298,      64'd0};
        tv[2]  = '{2'd0, 32'h7FFFFFFF,   32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 64'h3FFFFFFF00000001, 32'h7FFFFFFF, 64'd0};
        tv[3]  = '{2'd3, 32'h80000000,   32'h7FFFFFFF, 1'b1, 1'b0, 1'b0, 64'hC000000080000000, 32'h80000000, 64'd0};
        tv[4]  = '{2'd1, 32'd3,          32'd32768,    1'b1, 1'b0, 1'b0, 64'h18000,            32'd2,        64'd0};
        tv[5]  = '{2'd2, 32'hFFFFFFFD,   32'd32768,    1'b1, 1'b0, 1'b0, 64'hFFFFFFFFFFFE8000, 32'hFFFFFFFF, 64'd0};
        tv[6]  = '{2'd0, 32'h80000000,   32'h80000000, 1'b0, 1'b1, 1'b1, 64'h4000000000000000, 32'd0,        64'h4000000000000000};
        tv[7]  = '{2'd0, 32'h80000000,   32'h80000000, 1'b0, 1'b1, 1'b0, 64'h4000000000000000, 32'd0,        64'h7FFFFFFFFFFFFFFF};
        tv[8]  = '{2'd3, 32'h80000000,   32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 64'hC000000080000000, 32'h80000000, 64'h400000007FFFFFFF};
        tv[9]  = '{2'd1, 32'd3,          32'hFFFFFFFB, 1'b0, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFF1, 32'hFFFFFFF1, 64'h400000007FFFFFFF};
        tv[10] = '{2'd0, 32'hFFFFFFFF,   32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 64'd1,                32'd0,        64'h400000007FFFFFFF};

        // Reset held while inputs toggle.
        rst_n = 1'b0;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk_all("reset", 1'b0, 2'd0, 64'd0, 32'd0, 64'd0);
            drive(1'b1, 2'($urandom), $urandom, $urandom, 1'b1, 1'b1, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("idle after reset valid", 64'(out_valid), 64'd0);
        end

        // Table stream, issued back to back; results appear two edges later.
        for (int c = 0; c < N + 2; c++) begin
            @(negedge clk);
            if (c >= 2)
                chk_all($sformatf("vec%0d", c-2), 1'b1, tv[c-2].sel, tv[c-2].p, tv[c-2].r, tv[c-2].ac);
            if (c < N) drive(1'b1, tv[c].sel, tv[c].a, tv[c].b, tv[c].mode, tv[c].acc, tv[c].clr);
            else       drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        chk_all("bubble hold", 1'b0, tv[N-1].sel, tv[N-1].p, tv[N-1].r, tv[N-1].ac);

        // Back-to-back MAC: a=1..8, b=2, clear on the first.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c >= 2) begin
                chk($sformatf("mac%0d valid", c-2), 64'(out_valid), 64'd1);
                chk($sformatf("mac%0d product", c-2), out_product, 64'(2*(c-1)));
                chk($sformatf("mac%0d acc", c-2), out_acc, 64'((c-1)*c));
            end
            if (c < 8) drive(1'b1, 2'd0, 32'(c+1), 32'd2, 1'b0, 1'b1, c == 0);
            else       drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        end
        @(negedge clk);
        drive(1'b1, 2'd0, 32'd5, 32'd5, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("clr latency valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk_all("clr", 1'b1, 2'd0, 64'd25, 32'd25, 64'd25);

        // Reset mid-stream discards in-flight work.
        @(negedge clk);
        drive(1'b1, 2'd1, 32'd7, 32'd7, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        drive(1'b1, 2'd2, 32'd9, 32'd9, 1'b0, 1'b1, 1'b0);
        #1 rst_n = 1'b0;
        #1 chk_all("async reset", 1'b0, 2'd0, 64'd0, 32'd0, 64'd0);
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk_all("post reset", 1'b0, 2'd0, 64'd0, 32'd0, 64'd0);
        end
        drive(1'b1, 2'd3, 32'd7, 32'd6, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        drive(1'b0, 2'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("fresh latency valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk_all("fresh", 1'b1, 2'd3, 64'd42, 32'd42, 64'd42);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
